score_port: RTL
===============

# score_port

Nios II multi-cycle custom-instruction responder that returns game state to software, the read-back counterpart of the paddle-coordinate write path. It counts goals from the ball logic, holds both player scores and a game-over flag, and answers software opcodes (read score, clear, set winning score, read events) through the CPU's start/done handshake. It sits next to the VGA top level, shares `CLK`, and drives the custom instruction's `result` bus.

## Interface
- `WIN_SCORE`, 7: default winning score, used after reset and when software loads 0.
- `SCORE_W`, 8: width of each score counter.
- `CLK` in 1: board clock; every flop is on its rising edge.
- `RST_BTN` in 1: reset, synchronous, active-low.
- `CLK_EN` in 1: custom-instruction clock enable; gates the handshake FSM only.
- `START` in 1: instruction start, sampled when `CLK_EN`=1.
- `N` in 2: opcode.
- `dataa` in 32: operand.
- `GOAL_L` in 1: ball is past the left edge (point to player 2); level, may stay high many cycles.
- `GOAL_R` in 1: ball is past the right edge (point to player 1).
- `DONE` out 1: result valid / instruction complete.
- `result` out 32: instruction result.
- `GAME_OVER` out 1: a score has reached the winning score.

## Operation
- Goal detection runs every `CLK` cycle, independent of `CLK_EN`. It uses rising-edge detection, so each `GOAL_*` high period scores exactly one point.
- The rising edge of `GOAL_R` increments `score1`. The rising edge of `GOAL_L` increments `score2`. If both edges occur in the same cycle, both scores increment.
- When a score equals `win` after an increment, `GAME_OVER` sets. While `GAME_OVER`=1, goal edges are ignored and the scores are frozen.
- Opcodes:
  - 0 READ_SCORE: `result` = {`GAME_OVER`, 15'b0, `score2`[7:0], `score1`[7:0]}.
  - 1 CLEAR: zeroes both scores, `GAME_OVER` and event flags; `result` = 0.
  - 2 SET_WIN: loads `win` from `dataa`[7:0], or `WIN_SCORE` if that field is 0; `result` = new `win`. `GAME_OVER` is recomputed on the next cycle as (`score1`≥`win` or `score2`≥`win`).
  - 3 READ_EVENTS: see Configuration.
- FSM states: IDLE, EXEC, RESP. All transitions require `CLK_EN`=1.
  - IDLE→EXEC when `START`=1; `N` and `dataa` are latched.
  - EXEC→RESP: performs the opcode and registers `result`.
  - RESP→IDLE: `DONE`=1 for this state only.
- `START` in EXEC or RESP is ignored.
- A CLEAR executing in the same cycle as a goal edge: the clear wins and the point is dropped.

## Timing
- Reset values: `DONE`=0, `result`=0, `GAME_OVER`=0, scores 0, `win`=`WIN_SCORE`, event flags 0, FSM in IDLE. The edge-detect history registers load the current inputs, so a goal level held through reset does not score.
- Latency: with `CLK_EN` held high, `DONE` rises 2 cycles after the `START` cycle and stays high for 1 cycle.
- `result` holds its value until the next EXEC.
- If `CLK_EN` drops, the FSM stalls in its current state. `DONE`/`result` stay registered.
- A score update is visible to READ_SCORE 1 cycle after the goal edge.
- Score counters never wrap. They stop at `win`, or at 2^`SCORE_W`−1 if `win` is larger.
- Reset asserted mid-instruction returns the FSM to IDLE with `DONE`=0. No `DONE` is produced for the aborted instruction.

## Configuration
- `SCORE_PORT_EVENTS_EN` defined:
  - Two sticky flags, `evt1` and `evt2`, set on each goal edge that scores.
  - Opcode 3 returns {30'b0, `evt2`, `evt1`} and clears the flags in EXEC.
  - A goal edge in that same cycle re-sets its flag; set has priority over clear.
- Not defined:
  - No event flags exist.
  - Opcode 3 returns 0 and has no side effects.

## Structure
- Package `pong_pkg`: opcode constants (`OP_READ_SCORE`, `OP_CLEAR`, `OP_SET_WIN`, `OP_READ_EVENTS`), FSM state enum, `SCORE_W` default, and result field bit positions.
- Sub-module `edge_pulse`: registered rising-edge detector with synchronous active-low reset, instantiated once per goal input.

## Test plan
- Reset, then `GOAL_R` high for 5 cycles, then low; READ_SCORE → `result`=0x0000_0001, and `DONE` exactly 2 cycles after `START`.
- `GOAL_L` and `GOAL_R` rise in the same cycle, 3 times → `result`=0x0000_0303.
- SET_WIN with `dataa`=2, then 3 `GOAL_R` edges → `score1`=2, `GAME_OVER`=1, READ_SCORE = 0x8000_0002; then CLEAR → READ_SCORE = 0.
- CLEAR executing in the same cycle as a `GOAL_L` edge → scores 0. `START` pulsed during RESP → no second `DONE`.
- `CLK_EN` low for 4 cycles in EXEC → `DONE` delayed by exactly 4 cycles. Reset in RESP → `DONE`=0 on the next cycle.
- With `SCORE_PORT_EVENTS_EN`: one `GOAL_L` edge, then READ_EVENTS → 0x2; a second READ_EVENTS → 0x0.

Source files
------------

// File: rtl/pong_pkg.sv
// pong_pkg: shared opcodes, FSM states and result-field layout for the pong score port.
// Revision 1.0
`default_nettype none

package pong_pkg;

  localparam int SCORE_W_DEF = 8;

  localparam logic [1:0] OP_READ_SCORE  = 2'd0;
  localparam logic [1:0] OP_CLEAR       = 2'd1;
  localparam logic [1:0] OP_SET_WIN     = 2'd2;
  localparam logic [1:0] OP_READ_EVENTS = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } fsm_state_e;

  localparam int RES_GAME_OVER_BIT = 31;
  localparam int RES_SCORE2_LSB    = 8;
  localparam int RES_SCORE1_LSB    = 0;
  localparam int RES_SCORE_FLD_W   = 8;
  localparam int RES_EVT1_BIT      = 0;
  localparam int RES_EVT2_BIT      = 1;

endpackage

`default_nettype wire

// File: rtl/score_port_if.sv
// score_port_if: Nios II multi-cycle custom-instruction handshake bundle.
// Revision 1.0
`default_nettype none

interface score_port_if;
  logic        CLK_EN;
  logic        START;
  logic [1:0]  N;
  logic [31:0] dataa;
  logic        DONE;
  logic [31:0] result;

  modport master (output CLK_EN, START, N, dataa, input DONE, result);
  modport slave  (input CLK_EN, START, N, dataa, output DONE, result);
endinterface

`default_nettype wire

// File: rtl/edge_pulse.sv
// edge_pulse: rising-edge detector; history loads the live input during reset.
// Revision 1.0
`default_nettype none

module edge_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);

  logic prev_q;
  logic prev_d;

  always_comb prev_d = d;

  // Loading d under reset keeps a level held through reset from looking like an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) prev_q <= d;
    else        prev_q <= prev_d;
  end

  assign pulse = d & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/score_port.sv
// score_port: goal counter / game-over tracker answering custom-instruction opcodes.
// Revision 1.0 -- optional sticky event flags enabled by SCORE_PORT_EVENTS_EN.
`default_nettype none

module score_port
  import pong_pkg::*;
#(
  parameter int WIN_SCORE = 7,
  parameter int SCORE_W   = SCORE_W_DEF
) (
  input  logic         CLK,
  input  logic         RST_BTN,
  input  logic         GOAL_L,
  input  logic         GOAL_R,
  output logic         GAME_OVER,
  score_port_if.slave  ci
);

  localparam logic [1:0]         S_IDLE    = ST_IDLE;
  localparam logic [1:0]         S_EXEC    = ST_EXEC;
  localparam logic [1:0]         S_RESP    = ST_RESP;
  localparam logic [SCORE_W-1:0] WIN_DEF   = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  logic [1:0]         state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [7:0]         arg_q, arg_d;
  logic               done_q, done_d;
  logic [31:0]        result_q, result_d;
  logic [SCORE_W-1:0] score1_q, score1_d;
  logic [SCORE_W-1:0] score2_q, score2_d;
  logic [SCORE_W-1:0] win_q, win_d;
  logic               game_over_q, game_over_d;
  logic               recompute_q, recompute_d;

  logic goal_r_pulse, goal_l_pulse;
  logic exec_fire, do_clear, inc1, inc2;
  logic unused_dataa_hi;

  edge_pulse u_edge_r (.clk(CLK), .rst_n(RST_BTN), .d(GOAL_R), .pulse(goal_r_pulse));
  edge_pulse u_edge_l (.clk(CLK), .rst_n(RST_BTN), .d(GOAL_L), .pulse(goal_l_pulse));

  assign exec_fire = ci.CLK_EN && (state_q == S_EXEC);
  assign do_clear  = exec_fire && (op_q == OP_CLEAR);
  // A clear in the same cycle as a goal edge drops the point.
  assign inc1 = goal_r_pulse && !game_over_q && !do_clear && (score1_q != SCORE_MAX);
  assign inc2 = goal_l_pulse && !game_over_q && !do_clear && (score2_q != SCORE_MAX);
  assign unused_dataa_hi = ^ci.dataa[31:8];

`ifdef SCORE_PORT_EVENTS_EN
  logic evt1_q, evt1_d;
  logic evt2_q, evt2_d;

  always_comb begin
    evt1_d = evt1_q;
    evt2_d = evt2_q;
    if (do_clear || (exec_fire && (op_q == OP_READ_EVENTS))) begin
      evt1_d = 1'b0;
      evt2_d = 1'b0;
    end
    if (inc1) evt1_d = 1'b1;
    if (inc2) evt2_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_BTN) begin
      evt1_q <= 1'b0;
      evt2_q <= 1'b0;
    end else begin
      evt1_q <= evt1_d;
      evt2_q <= evt2_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    arg_d       = arg_q;
    done_d      = done_q;
    result_d    = result_q;
    win_d       = win_q;
    recompute_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ci.CLK_EN && ci.START) begin
          state_d = S_EXEC;
          op_d    = ci.N;
          arg_d   = ci.dataa[7:0];
        end
      end
      S_EXEC: begin
        if (ci.CLK_EN) begin
          state_d  = S_RESP;
          done_d   = 1'b1;
          result_d = '0;
          case (op_q)
            OP_READ_SCORE: begin
              result_d[RES_GAME_OVER_BIT]                 = game_over_q;
              result_d[RES_SCORE2_LSB +: RES_SCORE_FLD_W] = RES_SCORE_FLD_W'(score2_q);
              result_d[RES_SCORE1_LSB +: RES_SCORE_FLD_W] = RES_SCORE_FLD_W'(score1_q);
            end
            OP_CLEAR: result_d = '0;
            OP_SET_WIN: begin
              win_d       = (arg_q == 8'd0) ? WIN_DEF : SCORE_W'(arg_q);
              result_d    = 32'(win_d);
              recompute_d = 1'b1;
            end
            default: begin
`ifdef SCORE_PORT_EVENTS_EN
              result_d[RES_EVT1_BIT] = evt1_q;
              result_d[RES_EVT2_BIT] = evt2_q;
`else
              result_d = '0;
`endif
            end
          endcase
        end
      end
      S_RESP: begin
        if (ci.CLK_EN) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        done_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    score1_d    = score1_q;
    score2_d    = score2_q;
    game_over_d = game_over_q;
    if (inc1) score1_d = score1_q + 1'b1;
    if (inc2) score2_d = score2_q + 1'b1;
    if (do_clear) begin
      score1_d    = '0;
      score2_d    = '0;
      game_over_d = 1'b0;
    end else if (recompute_q) begin
      // The cycle after a win-score load re-judges the game against the new threshold.
      game_over_d = (score1_d >= win_q) || (score2_d >= win_q);
    end else if ((inc1 && (score1_d == win_q)) || (inc2 && (score2_d == win_q))) begin
      game_over_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_BTN) begin
      state_q     <= S_IDLE;
      op_q        <= OP_READ_SCORE;
      arg_q       <= '0;
      done_q      <= 1'b0;
      result_q    <= '0;
      score1_q    <= '0;
      score2_q    <= '0;
      win_q       <= WIN_DEF;
      game_over_q <= 1'b0;
      recompute_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      arg_q       <= arg_d;
      done_q      <= done_d;
      result_q    <= result_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      win_q       <= win_d;
      game_over_q <= game_over_d;
      recompute_q <= recompute_d;
    end
  end

  assign ci.DONE   = done_q;
  assign ci.result = result_q;
  assign GAME_OVER = game_over_q;

endmodule

`default_nettype wire
